multicycle_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the shared ALU, register file and unified memory port across several clock cycles per instruction. It replaces the single-cycle decode with a stepped controller. Instruction fetch and data access share one memory interface gated by a ready handshake. It sits between the instruction register's opcode/funct fields and the datapath enables.

---
 rtl/multicycle_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps one instruction through fetch, decode,
// execute, memory and write-back states, driving the shared ALU, register file
// and unified memory port enables. Memory accesses wait on mem_ready with a
// bounded wait counter; an overrun or illegal instruction parks in TRAP.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [5:0]       alu_op,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecMem = 4'd2,
    StMemRd   = 4'd3,
    StMemWr   = 4'd4,
    StWbMem   = 4'd5,
    StExecR   = 4'd6,
    StWbR     = 4'd7,
    StExecI   = 4'd8,
    StWbI     = 4'd9,
    StBranch  = 4'd10,
    StTrap    = 4'd15
  } state_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] AluAdd  = 6'b100000;
  localparam logic [5:0] AluSub  = 6'b100010;
  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             funct_ok;

  // Supported R-type function codes: add, sub, and, or, xor, nor.
  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b100110, 6'b100111: funct_ok = 1'b1;
      default:                         funct_ok = 1'b0;
    endcase
  end

  // Next-state, wait counter and retire counter. The wait counter only counts
  // while a memory-facing state stalls; every other path clears it, which also
  // covers the clear-on-entry to FETCH/MEM_RD/MEM_WR.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    retired_d = retired_q;
    case (state_q)
      StFetch, StMemRd, StMemWr: begin
        if (mem_ready) begin
          if (state_q == StFetch) begin
            state_d = StDecode;
          end else if (state_q == StMemRd) begin
            state_d = StWbMem;
          end else begin
            state_d   = StFetch;
            retired_d = retired_q + CNT_W'(1);
          end
        end else if (wait_q == TimeoutVal) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (opcode == OpLw || opcode == OpSw) begin
          state_d = StExecMem;
        end else if (opcode == OpRtype && funct_ok) begin
          state_d = StExecR;
        end else if (opcode == OpAddi) begin
          state_d = StExecI;
        end else if (opcode == OpBeq) begin
          state_d = StBranch;
        end else begin
          state_d = StTrap;
        end
      end
      StExecMem: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StWbMem, StWbR, StWbI, StBranch: begin
        state_d   = StFetch;
        retired_d = retired_q + CNT_W'(1);
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Moore output decode; FETCH and BRANCH additionally look at mem_ready/zero.
  // Outputs are forced idle while resetn is low so an abort issues no access.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = AluAdd;
    trap       = 1'b0;
    if (resetn) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        StDecode: alu_src_b = 2'b11;
        StExecMem: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRd: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        StMemWr: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        StWbMem: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = funct;
        end
        StWbR: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          alu_op    = funct;
        end
        StExecI: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StWbI: reg_write = 1'b1;
        StBranch: begin
          alu_src_a = 1'b1;
          alu_op    = AluSub;
          pc_src    = 1'b1;
          pc_write  = zero;
        end
        StTrap:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: each driven cycle pushes the
// expected output bundle and retire count to a scoreboard queue, which is
// popped and compared at the following falling clock edge.
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_src, ir_write, iord, mem_read, mem_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, trap;
  logic [1:0]  alu_src_b;
  logic [5:0]  alu_op;
  logic [3:0]  state;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned retired_m = 0;

  typedef struct {
    logic [22:0] vec;
    logic [15:0] ret;
  } exp_t;
  exp_t sb_q[$];

  multicycle_sequencer #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .state(state),
    .retired(retired)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  // Observed bundle: {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
  // reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap}
  logic [22:0] obs;
  assign obs = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // Expected outputs for a state, written from the control table.
  function automatic logic [22:0] ev(input int st, input logic rdy, input logic z,
                                     input logic [5:0] fn);
    logic pw, ps, irw, io, mr, mw, rw, rdst, m2r, asa, trp;
    logic [1:0] asb;
    logic [5:0] op;
    logic [3:0] s4;
    pw = 0; ps = 0; irw = 0; io = 0; mr = 0; mw = 0; rw = 0; rdst = 0; m2r = 0;
    asa = 0; trp = 0; asb = 2'b00; op = 6'b100000;
    s4 = st[3:0];
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin io = 1; mr = 1; end
      4:  begin io = 1; mw = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin asa = 1; op = fn; end
      7:  begin rw = 1; rdst = 1; op = fn; end
      8:  begin asa = 1; asb = 2'b10; end
      9:  rw = 1;
      10: begin asa = 1; op = 6'b100010; ps = 1; pw = z; end
      default: trp = 1;
    endcase
    return {s4, pw, ps, irw, io, mr, mw, rw, rdst, m2r, asa, asb, op, trp};
  endfunction

  // One clock cycle: drive, push expectation, compare at the falling edge.
  task automatic step(input int st, input logic rdy, input logic z, input logic [5:0] fn,
                      input string tag);
    exp_t e;
    mem_ready = rdy;
    zero = z;
    funct = fn;
    e.vec = ev(st, rdy, z, fn);
    e.ret = 16'(retired_m);
    sb_q.push_back(e);
    @(negedge clock);
    e = sb_q.pop_front();
    check($sformatf("%s_st%0d", tag, st), 64'(obs), 64'(e.vec));
    check($sformatf("%s_retired", tag), 64'(retired), 64'(e.ret));
    @(posedge clock);
    #1;
  endtask

  // Assert reset mid-cycle: outputs must go idle immediately.
  task automatic reset_dut();
    resetn = 1'b0;
    mem_ready = 1'b1;
    retired_m = 0;
    #1;
    check("reset_async", 64'({obs, retired}), 64'({4'd0, 10'b0, 2'b00, 6'b100000, 1'b0, 16'd0}));
    @(posedge clock);
    @(negedge clock);
    check("reset_hold", 64'({obs, retired}), 64'({4'd0, 10'b0, 2'b00, 6'b100000, 1'b0, 16'd0}));
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Walk one instruction through its expected state path.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int stalls, input string tag);
    int st[$];
    logic rd[$];
    logic rt_ok;
    rt_ok = (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b100110 || fn == 6'b100111);
    opcode = op;
    st.push_back(0);  rd.push_back(1'b1);
    st.push_back(1);  rd.push_back(1'($urandom_range(0, 1)));
    if (op == 6'b100011 || op == 6'b101011) begin
      st.push_back(2); rd.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < stalls; i++) begin
        st.push_back(op == 6'b100011 ? 3 : 4); rd.push_back(1'b0);
      end
      st.push_back(op == 6'b100011 ? 3 : 4); rd.push_back(1'b1);
      if (op == 6'b100011) begin
        st.push_back(5); rd.push_back(1'($urandom_range(0, 1)));
      end
    end else if (op == 6'b000000 && rt_ok) begin
      st.push_back(6); rd.push_back(1'($urandom_range(0, 1)));
      st.push_back(7); rd.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b001000) begin
      st.push_back(8); rd.push_back(1'($urandom_range(0, 1)));
      st.push_back(9); rd.push_back(1'($urandom_range(0, 1)));
    end else if (op == 6'b000100) begin
      st.push_back(10); rd.push_back(1'($urandom_range(0, 1)));
    end else begin
      st.push_back(15); rd.push_back(1'($urandom_range(0, 1)));
    end
    foreach (st[i]) step(st[i], rd[i], z, fn, tag);
    if (st[st.size()-1] != 15) retired_m++;
  endtask

  logic [5:0] rfn[6];

  initial begin
    rfn[0] = 6'b100000; rfn[1] = 6'b100010; rfn[2] = 6'b100100;
    rfn[3] = 6'b100101; rfn[4] = 6'b100111; rfn[5] = 6'b100110;
    @(posedge clock);
    #1;
    reset_dut();

    foreach (rfn[i]) run_instr(6'b000000, rfn[i], 1'b0, 0, "rtype");
    check("rtype_retired6", 64'(retired), 64'd6);

    run_instr(6'b100011, 6'b000000, 1'b0, 3, "lw");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, "sw");
    run_instr(6'b101011, 6'b000000, 1'b0, 2, "sw_stall");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, "beq_not");
    run_instr(6'b001000, 6'b000000, 1'b0, 0, "addi");
    check("mix_retired", 64'(retired), 64'd12);

    // Abort mid-instruction.
    opcode = 6'b001000;
    step(0, 1'b1, 1'b0, 6'b0, "abort");
    step(1, 1'b0, 1'b0, 6'b0, "abort");
    step(8, 1'b1, 1'b0, 6'b0, "abort");
    reset_dut();

    // Illegal opcode and unsupported R-type funct both trap; trap is absorbing.
    run_instr(6'b111111, 6'b000000, 1'b0, 0, "illegal");
    for (int i = 0; i < 3; i++) step(15, 1'($urandom_range(0, 1)), 1'b1, 6'b0, "trap_hold");
    reset_dut();
    run_instr(6'b000000, 6'b001000, 1'b0, 0, "bad_funct");
    reset_dut();

    // Fetch timeout: 16 waiting cycles, then TRAP.
    opcode = 6'b000000;
    for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b0, 6'b100000, "timeout");
    step(15, 1'b0, 1'b0, 6'b100000, "timeout_trap");
    step(15, 1'b1, 1'b0, 6'b100000, "timeout_trap");
    reset_dut();

    // Ready on the 16th waiting cycle wins over the timeout.
    for (int i = 0; i < 15; i++) step(0, 1'b0, 1'b0, 6'b100000, "late_ready");
    run_instr(6'b000000, 6'b100000, 1'b0, 0, "late_ready");
    check("late_ready_retired", 64'(retired), 64'd1);

    // Memory-read timeout inside an lw.
    opcode = 6'b100011;
    step(0, 1'b1, 1'b0, 6'b0, "rd_timeout");
    step(1, 1'b0, 1'b0, 6'b0, "rd_timeout");
    step(2, 1'b0, 1'b0, 6'b0, "rd_timeout");
    for (int i = 0; i < 16; i++) step(3, 1'b0, 1'b0, 6'b0, "rd_timeout");
    step(15, 1'b1, 1'b0, 6'b0, "rd_timeout_trap");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
